// File: rtl/cellrv32_package.sv
// Shared types and constants for the cellrv32 TRNG entropy path.
package cellrv32_package;

  typedef enum logic {
    VN_FIRST  = 1'b0,
    VN_SECOND = 1'b1
  } vn_state_t;

  localparam logic [15:0] trng_lfsr_seed_c = 16'hACE1;
  localparam logic [15:0] trng_lfsr_taps_c = 16'hB400;

  // Galois step for x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] trng_lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ trng_lfsr_taps_c) : (s >> 1);
  endfunction

endpackage

// File: rtl/cellrv32_trng_health.sv
// Repetition-count health test: flags a stuck source after STUCK_LIMIT identical samples.
module cellrv32_trng_health #(
  parameter int STUCK_LIMIT = 32
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic enable_i,
  input  logic sample_en_i,
  input  logic smp_i,
  output logic hit_o,
  output logic stuck_o
);
  localparam int CW = $clog2(STUCK_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STUCK_LIMIT);

  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic          prev_q, prev_d;
  logic          stuck_q, stuck_d;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    prev_d    = prev_q;
    stuck_d   = stuck_q;
    hit_o     = 1'b0;
    if (!enable_i) begin
      rep_cnt_d = '0;
      prev_d    = 1'b0;
      stuck_d   = 1'b0;
    end else if (sample_en_i) begin
      prev_d = smp_i;
      if (smp_i == prev_q) begin
        if (rep_cnt_q != LIMIT_C) rep_cnt_d = rep_cnt_q + CW'(1);
      end else begin
        rep_cnt_d = CW'(1);
      end
      // hit_o lets the extractor block the very sample that trips the flag
      if (rep_cnt_d == LIMIT_C) begin
        hit_o   = 1'b1;
        stuck_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rep_cnt_q <= '0;
      prev_q    <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      prev_q    <= prev_d;
      stuck_q   <= stuck_d;
    end
  end

  assign stuck_o = stuck_q;

endmodule

// File: rtl/cellrv32_trng_extractor.sv
// TRNG extractor: sync/decimate raw bit, von Neumann debias, health check, byte packing,
// optional fold of 8 assembled bytes into one output byte.
module cellrv32_trng_extractor
  import cellrv32_package::*;
#(
  parameter logic SIM_MODE     = 1'b0,
  parameter logic POST_PROC_EN = 1'b1,
  parameter int   SAMPLE_DIV   = 1,
  parameter int   STUCK_LIMIT  = 32
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       enable_i,
  input  logic       raw_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       stuck_o
);
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  if (SAMPLE_DIV < 1) begin : g_chk_div
    $error("SAMPLE_DIV must be >= 1");
  end
  if (STUCK_LIMIT < 2) begin : g_chk_limit
    $error("STUCK_LIMIT must be >= 2");
  end

  logic [1:0]    sync_q, sync_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [DW-1:0] div_q, div_d;
  vn_state_t     vn_q, vn_d;
  logic          b0_q, b0_d;
  logic [6:0]    sreg_q, sreg_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    acc_q, acc_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          smp, sample_en, emit, hit;
  logic [7:0]    byte_w, fold_w;

  // SIM_MODE swaps the ring oscillator for a deterministic PRNG; simulation only
  assign smp       = SIM_MODE ? lfsr_q[0] : sync_q[1];
  assign sample_en = (div_q == '0);
  assign byte_w    = {sreg_q, b0_q};
  assign fold_w    = {acc_q[6:0], acc_q[7]} ^ byte_w;

  cellrv32_trng_health #(
    .STUCK_LIMIT(STUCK_LIMIT)
  ) u_health (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .enable_i   (enable_i),
    .sample_en_i(sample_en),
    .smp_i      (smp),
    .hit_o      (hit),
    .stuck_o    (stuck_o)
  );

  always_comb begin
    sync_d     = {sync_q[0], raw_i};
    lfsr_d     = trng_lfsr_next(lfsr_q);
    div_d      = (div_q == DW'(SAMPLE_DIV - 1)) ? '0 : div_q + DW'(1);
    vn_d       = vn_q;
    b0_d       = b0_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    acc_d      = acc_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    emit       = 1'b0;

    if (sample_en) begin
      case (vn_q)
        VN_FIRST: begin
          b0_d = smp;
          vn_d = VN_SECOND;
        end
        VN_SECOND: begin
          emit = (b0_q != smp);
          vn_d = VN_FIRST;
        end
      endcase
    end

    if (emit && !stuck_o && !hit) begin
      sreg_d    = byte_w[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        if (POST_PROC_EN) begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) begin
            data_d  = fold_w;
            valid_d = 1'b1;
            acc_d   = '0;
          end else begin
            acc_d = fold_w;
          end
        end else begin
          data_d  = byte_w;
          valid_d = 1'b1;
        end
      end
    end

    if (!enable_i) begin
      sync_d     = '0;
      lfsr_d     = trng_lfsr_seed_c;
      div_d      = '0;
      vn_d       = VN_FIRST;
      b0_d       = 1'b0;
      sreg_d     = '0;
      bit_cnt_d  = '0;
      acc_d      = '0;
      byte_cnt_d = '0;
      data_d     = '0;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q     <= '0;
      lfsr_q     <= trng_lfsr_seed_c;
      div_q      <= '0;
      vn_q       <= VN_FIRST;
      b0_q       <= 1'b0;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      acc_q      <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      lfsr_q     <= lfsr_d;
      div_q      <= div_d;
      vn_q       <= vn_d;
      b0_q       <= b0_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_q      <= acc_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_cellrv32_trng_extractor.sv
// Bench for cellrv32_trng_extractor: directed vector table, hand sequences and randomized
// streams scored against a sample-list reference model.
module tb_cellrv32_trng_extractor;
  localparam int LIMIT = 32;
  localparam int NV    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, en, raw, en_s;
  logic [7:0] d0, d1, ds1, ds4;
  logic       v0, v1, vs1, vs4, st0, st1, sts1, sts4;
  int         errors = 0, checks = 0, cyc = 0, cyc_en0 = 0;
  logic [7:0] q0[$], q1[$], qs1[$], qs4[$];
  int         ts4[$];

  typedef struct {
    string        name;
    logic [127:0] pre;
    int           pre_n;
    logic [127:0] pat;
    int           n;
    int           exp_cnt;
    logic [7:0]   exp_b;
  } vec_t;
  vec_t vecs[NV];

  cellrv32_trng_extractor #(.SIM_MODE(1'b0), .POST_PROC_EN(1'b0), .SAMPLE_DIV(1), .STUCK_LIMIT(LIMIT))
    u_pp0 (.clk_i(clk), .rstn_i(rstn), .enable_i(en), .raw_i(raw), .data_o(d0), .valid_o(v0), .stuck_o(st0));
  cellrv32_trng_extractor #(.SIM_MODE(1'b0), .POST_PROC_EN(1'b1), .SAMPLE_DIV(1), .STUCK_LIMIT(LIMIT))
    u_pp1 (.clk_i(clk), .rstn_i(rstn), .enable_i(en), .raw_i(raw), .data_o(d1), .valid_o(v1), .stuck_o(st1));
  cellrv32_trng_extractor #(.SIM_MODE(1'b1), .POST_PROC_EN(1'b0), .SAMPLE_DIV(1), .STUCK_LIMIT(LIMIT))
    u_sim1 (.clk_i(clk), .rstn_i(rstn), .enable_i(en_s), .raw_i(raw), .data_o(ds1), .valid_o(vs1), .stuck_o(sts1));
  cellrv32_trng_extractor #(.SIM_MODE(1'b1), .POST_PROC_EN(1'b0), .SAMPLE_DIV(4), .STUCK_LIMIT(LIMIT))
    u_sim4 (.clk_i(clk), .rstn_i(rstn), .enable_i(en_s), .raw_i(raw), .data_o(ds4), .valid_o(vs4), .stuck_o(sts4));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0) q0.push_back(d0);
    if (v1) q1.push_back(d1);
    if (vs1) qs1.push_back(ds1);
    if (vs4) begin
      qs4.push_back(ds4);
      ts4.push_back(cyc - cyc_en0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    en = 1'b0;
    step();
    en = 1'b1;
  endtask

  task automatic apply(input logic [127:0] p, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      raw = p[i];
      step();
    end
  endtask

  task automatic flush();
    raw = 1'b0;
    repeat (4) step();
  endtask

  task automatic setv(input int i, input string nm, input logic [127:0] pre, input int pre_n,
                      input logic [127:0] pat, input int n, input int cnt, input logic [7:0] b);
    vecs[i].name = nm;  vecs[i].pre = pre; vecs[i].pre_n = pre_n;
    vecs[i].pat = pat;  vecs[i].n = n;     vecs[i].exp_cnt = cnt; vecs[i].exp_b = b;
  endtask

  // Reference: sample list -> stuck point, VN pairs, MSB-first bytes, 8-byte folds.
  // bidx/fidx give the sample index that completes each byte/fold.
  task automatic model(input bit smp[$], output logic [7:0] bytes[$], output int bidx[$],
                       output logic [7:0] folds[$], output int fidx[$], output int stuck_at);
    bit         bits[$];
    int         bitidx[$];
    int         run;
    logic [7:0] v, acc;
    stuck_at = -1;
    run = 0;
    for (int i = 0; i < smp.size(); i++) begin
      run = (i > 0 && smp[i] == smp[i-1]) ? run + 1 : 1;
      if (run >= LIMIT) begin
        stuck_at = i;
        break;
      end
    end
    for (int k = 0; 2 * k + 1 < smp.size(); k++) begin
      if (stuck_at >= 0 && 2 * k + 1 >= stuck_at) break;
      if (smp[2*k] != smp[2*k+1]) begin
        bits.push_back(smp[2*k]);
        bitidx.push_back(2 * k + 1);
      end
    end
    bytes.delete(); bidx.delete(); folds.delete(); fidx.delete();
    for (int b = 0; b + 8 <= bits.size(); b += 8) begin
      v = '0;
      for (int j = 0; j < 8; j++) v = {v[6:0], bits[b+j]};
      bytes.push_back(v);
      bidx.push_back(bitidx[b+7]);
    end
    for (int y = 0; y + 8 <= bytes.size(); y += 8) begin
      acc = '0;
      for (int j = 0; j < 8; j++) acc = {acc[6:0], acc[7]} ^ bytes[y+j];
      folds.push_back(acc);
      fidx.push_back(bidx[y+7]);
    end
  endtask

  task automatic run_random(input int n, input int one_pct, input string tag);
    bit         sm[$];
    logic [7:0] eb[$], ef[$];
    int         bi[$], fi[$];
    int         sa;
    bit         b;
    clear();
    q0.delete();
    q1.delete();
    sm.push_back(1'b0);
    sm.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      b = ($urandom_range(99) < one_pct);
      sm.push_back(b);
      raw = b;
      step();
    end
    sm.push_back(1'b0);
    sm.push_back(1'b0);
    flush();
    model(sm, eb, bi, ef, fi, sa);
    chk($sformatf("rnd%s byte count", tag), q0.size(), eb.size());
    for (int i = 0; i < eb.size() && i < q0.size(); i++)
      chk($sformatf("rnd%s byte%0d", tag, i), q0[i], eb[i]);
    chk($sformatf("rnd%s fold count", tag), q1.size(), ef.size());
    for (int i = 0; i < ef.size() && i < q1.size(); i++)
      chk($sformatf("rnd%s fold%0d", tag, i), q1[i], ef[i]);
    chk($sformatf("rnd%s stuck", tag), st0, (sa >= 0) ? 1 : 0);
  endtask

  task automatic sim_expect(input int d, output logic [7:0] eb[$], output int et[$]);
    bit         sm[$];
    logic [15:0] s;
    logic [7:0] fo[$];
    int         bi[$], fi[$];
    int         sa;
    s = 16'hACE1;
    for (int c = 0; c < 6000; c++) begin
      if (c % d == 0) sm.push_back(s[0]);
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
    model(sm, eb, bi, fo, fi, sa);
    et.delete();
    for (int k = 0; k < bi.size(); k++) et.push_back(bi[k] * d + 1);
  endtask

  task automatic sim_run(output logic [7:0] s1[$], output logic [7:0] s4[$], output int t4[$]);
    int guard;
    en_s = 1'b0;
    step();
    qs1.delete();
    qs4.delete();
    ts4.delete();
    en_s = 1'b1;
    cyc_en0 = cyc;
    guard = 0;
    while ((qs1.size() < 16 || qs4.size() < 16) && guard < 6000) begin
      step();
      guard++;
    end
    chk("sim 16 strobes within bound", (guard < 6000) ? 1 : 0, 1);
    s1 = qs1;
    s4 = qs4;
    t4 = ts4;
  endtask

  initial begin
    logic [7:0] eb1[$], eb4[$], r1a[$], r4a[$], r1b[$], r4b[$];
    int         et1[$], et4[$], t4a[$], t4b[$];
    int         diff;

    rstn = 1'b0; en = 1'b0; en_s = 1'b0; raw = 1'b0;
    repeat (3) step();
    chk("reset data_o", d0, 0);
    chk("reset valid_o", v0, 0);
    chk("reset stuck_o", st0, 0);
    chk("reset sim data_o", ds1, 0);
    rstn = 1'b1;
    step();

    setv(0, "T1 10x8",       128'h0,   0,  128'hAAAA,     16, 1, 8'hFF);
    setv(1, "T1 01x8",       128'h0,   0,  128'h5555,     16, 1, 8'h00);
    setv(2, "T2 AA+discard", 128'h0,   0,  128'h87878787, 32, 1, 8'hAA);
    setv(3, "01/10 x4",      128'h0,   0,  128'h6666,     16, 1, 8'h55);
    setv(4, "10x16",         128'h0,   0,  128'hAAAAAAAA, 32, 2, 8'hFF);
    setv(5, "T5 clear mid",  128'h155, 10, 128'hAAAA,     16, 1, 8'hFF);

    for (int v = 0; v < NV; v++) begin
      clear();
      if (vecs[v].pre_n > 0) begin
        apply(vecs[v].pre, vecs[v].pre_n);
        clear();
      end
      q0.delete();
      apply(vecs[v].pat, vecs[v].n);
      flush();
      chk({vecs[v].name, " count"}, q0.size(), vecs[v].exp_cnt);
      if (q0.size() > 0) chk({vecs[v].name, " first byte"}, q0[0], vecs[v].exp_b);
      chk({vecs[v].name, " data held"}, d0, vecs[v].exp_b);
    end

    // T3: eight bytes of 8'h01 fold to one 8'hFF
    clear();
    q0.delete();
    q1.delete();
    repeat (8) apply(128'h5556, 16);
    flush();
    chk("T3 fold strobes", q1.size(), 1);
    if (q1.size() > 0) chk("T3 fold byte", q1[0], 8'hFF);
    chk("T3 raw byte count", q0.size(), 8);
    if (q0.size() == 8) chk("T3 raw byte7", q0[7], 8'h01);

    // T4: stuck source
    clear();
    q0.delete();
    for (int k = 1; k <= 40; k++) begin
      raw = 1'b1;
      step();
      if (k == 33) chk("T4 stuck before 32nd sample", st0, 0);
      if (k == 34) chk("T4 stuck at 32nd sample", st0, 1);
    end
    apply(128'hAAAAAAAA, 32);
    flush();
    chk("T4 no strobe while stuck", q0.size(), 0);
    chk("T4 stuck sticky", st0, 1);
    en = 1'b0;
    step();
    chk("T4 stuck cleared by enable", st0, 0);
    chk("T4 data cleared by enable", d0, 0);
    en = 1'b1;

    run_random(1200, 50, "A");
    run_random(1000, 50, "B");
    run_random(1200, 94, "C");

    // T6: PRNG mode, repeatability and decimation timing
    sim_expect(1, eb1, et1);
    sim_expect(4, eb4, et4);
    sim_run(r1a, r4a, t4a);
    diff = 0;
    for (int i = 1; i < 16 && i < r1a.size(); i++) if (r1a[i] != r1a[0]) diff = 1;
    chk("T6 bytes not all equal", diff, 1);
    for (int i = 0; i < 16 && i < r1a.size(); i++) chk($sformatf("T6 div1 byte%0d", i), r1a[i], eb1[i]);
    for (int i = 0; i < 16 && i < r4a.size(); i++) chk($sformatf("T6 div4 byte%0d", i), r4a[i], eb4[i]);
    for (int i = 0; i < 16 && i < t4a.size(); i++) chk($sformatf("T6 div4 strobe time%0d", i), t4a[i], et4[i]);
    sim_run(r1b, r4b, t4b);
    for (int i = 0; i < 16 && i < r1b.size() && i < r1a.size(); i++)
      chk($sformatf("T6 repeat byte%0d", i), r1b[i], r1a[i]);
    for (int i = 0; i < 16 && i < r4b.size(); i++) chk($sformatf("T6 repeat div4 byte%0d", i), r4b[i], eb4[i]);
    chk("T6 sim not stuck", sts1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
